fixed_power: RTL and testbench

- Iterative fixed-point power unit: out_data = base^n.
  - base is an unsigned Q10.10 value.
  - n is a 3-bit unsigned integer exponent.
- Forward counterpart of the nth-root block. It raises a Q10.10 root back to the integer exponent, for self-checking and for pipeline stages that need x^n.
- One shared multiplier, multi-cycle FSM.
- Single-pulse valid handshake, matching the root and division blocks.

---
 rtl/fixed_power.sv | 171 +++++++++++++++++
 tb/tb_fixed_power.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_power.sv
// -----------------------------------------------------------------------------
// fixed_power
//
// Iterative fixed-point power unit: out_data = in_data_1 ^ in_data_2.
// The base is unsigned Q(INT_W).(FRAC_W) and the exponent is an unsigned
// EXP_W-bit integer. One shared multiplier is used, one multiply per cycle.
// A product whose integer part does not fit saturates the result to all ones
// and raises out_ovf; the multiply loop exits early in that case.
//
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous, active-low reset
//   in_valid   single-cycle request strobe, only sampled while idle
//   in_data_1  base, unsigned Q(INT_W).(FRAC_W)
//   in_data_2  exponent n, 0 .. 2^EXP_W-1
//   busy       high whenever a request is in flight
//   out_valid  single-cycle result strobe
//   out_data   result, zero while out_valid is low
//   out_ovf    saturation flag, zero while out_valid is low
// -----------------------------------------------------------------------------
module fixed_power #(
   parameter int INT_W  = 10,
   parameter int FRAC_W = 10,
   parameter int EXP_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic [INT_W+FRAC_W-1:0] in_data_1,
   input  logic [EXP_W-1:0]        in_data_2,
   output logic                    busy,
   output logic                    out_valid,
   output logic [INT_W+FRAC_W-1:0] out_data,
   output logic                    out_ovf
);

   localparam int W  = INT_W + FRAC_W;
   localparam int PW = 2 * W;
   localparam int SW = PW - FRAC_W;   // width of the product after rescaling

   localparam logic [W-1:0] ONE = W'(1) << FRAC_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_OUT
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      base_q, base_d;
   logic [W-1:0]      acc_q, acc_d;
   logic [EXP_W-1:0]  n_q, n_d;
   logic [EXP_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              out_stage_q, out_stage_d;
   logic              out_valid_q, out_valid_d;
   logic [W-1:0]      out_data_q, out_data_d;
   logic              out_ovf_q, out_ovf_d;

   // Product rescaled by 2^-FRAC_W (truncation toward zero). The upper INT_W
   // bits are the part that no longer fits the result format.
   logic [SW-1:0]     prod_scaled;
   logic [SW-W-1:0]   prod_excess;
   logic [W-1:0]      prod_keep;
   logic [EXP_W-1:0]  count_inc;

   assign prod_scaled = SW'((PW'(acc_q) * PW'(base_q)) >> FRAC_W);
   assign prod_excess = prod_scaled[SW-1:W];
   assign prod_keep   = prod_scaled[W-1:0];
   assign count_inc   = count_q + EXP_W'(1);

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      acc_d       = acc_q;
      n_d         = n_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      out_stage_d = out_stage_q;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_ovf_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               base_d      = in_data_1;
               n_d         = in_data_2;
               ovf_d       = 1'b0;
               out_stage_d = 1'b0;
               count_d     = EXP_W'(1);
               if (in_data_2 == '0) begin
                  // 0^0 is defined as 1.0 like any other x^0
                  acc_d   = ONE;
                  state_d = S_OUT;
               end else if (in_data_2 == EXP_W'(1)) begin
                  acc_d   = in_data_1;
                  state_d = S_OUT;
               end else begin
                  acc_d   = in_data_1;
                  state_d = S_MUL;
               end
            end
         end

         S_MUL: begin
            if (prod_excess != '0) begin
               acc_d   = '1;
               ovf_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               acc_d   = prod_keep;
               count_d = count_inc;
               if (count_inc == n_q) begin
                  state_d = S_OUT;
               end
            end
         end

         S_OUT: begin
            // First OUT cycle lets the final accumulator settle; the second
            // presents it on the registered output port and frees the unit.
            if (!out_stage_q) begin
               out_stage_d = 1'b1;
            end else begin
               out_stage_d = 1'b0;
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               out_ovf_d   = ovf_q;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         acc_q       <= '0;
         n_q         <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         out_stage_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_stage_q <= out_stage_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fixed_power.sv
// -----------------------------------------------------------------------------
// tb_fixed_power
//
// Directed bench for fixed_power. Each scenario task drives its own stimulus
// and compares outputs against hand-computed values; latency is counted in
// rising edges from the edge that accepts the request.
// -----------------------------------------------------------------------------
module tb_fixed_power;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [19:0] in_data_1;
   logic [2:0]  in_data_2;
   logic        busy;
   logic        out_valid;
   logic [19:0] out_data;
   logic        out_ovf;

   int vectors;
   int miscompares;

   fixed_power #(
      .INT_W (10),
      .FRAC_W(10),
      .EXP_W (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data_1(in_data_1),
      .in_data_2(in_data_2),
      .busy     (busy),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ovf  (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] base;
      logic [2:0]  n;
      logic [19:0] exp_data;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   // Present one request; returns just after the accepting edge.
   task automatic issue(input logic [19:0] b, input logic [2:0] n);
      @(negedge clk);
      in_data_1 = b;
      in_data_2 = n;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   // Counts edges until out_valid is seen; -1 if it never arrives.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data_1 = '0;
      in_data_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      vectors++;
      if (out_data !== 20'h00000) begin
         miscompares++;
         $display("FAIL reset_out_data got %h want 00000", out_data);
      end
      vectors++;
      if (out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_ovf got %b want 0", out_ovf);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset released");
   endtask

   task automatic test_power_table();
      vec_t tbl [0:13];
      int   lat;
      tbl[0]  = '{20'h00800, 3'd3, 20'h02000, 1'b0, 4};  // 2.0^3
      tbl[1]  = '{20'h00C00, 3'd3, 20'h06C00, 1'b0, 4};  // 3.0^3 root round trip
      tbl[2]  = '{20'h00A00, 3'd7, 20'h98968, 1'b0, 8};  // 2.5^7 exact, no ovf
      tbl[3]  = '{20'h00400, 3'd7, 20'h00400, 1'b0, 8};  // 1.0^7
      tbl[4]  = '{20'h00600, 3'd2, 20'h00900, 1'b0, 3};  // 1.5^2
      tbl[5]  = '{20'h00466, 3'd7, 20'h007C4, 1'b0, 8};  // 1.1^7 truncated
      tbl[6]  = '{20'h00001, 3'd2, 20'h00000, 1'b0, 3};  // underflow to 0
      tbl[7]  = '{20'h12345, 3'd0, 20'h00400, 1'b0, 2};  // x^0
      tbl[8]  = '{20'h00000, 3'd0, 20'h00400, 1'b0, 2};  // 0^0
      tbl[9]  = '{20'h12345, 3'd1, 20'h12345, 1'b0, 2};  // x^1
      tbl[10] = '{20'h00000, 3'd5, 20'h00000, 1'b0, 6};  // 0^5
      tbl[11] = '{20'h08000, 3'd3, 20'hFFFFF, 1'b1, 3};  // 32^3, sat at mult 1
      tbl[12] = '{20'h00C00, 3'd7, 20'hFFFFF, 1'b1, 8};  // 3^7, sat at mult 6
      tbl[13] = '{20'hFFFFF, 3'd2, 20'hFFFFF, 1'b1, 3};  // max^2
      for (int i = 0; i < 14; i++) begin
         issue(tbl[i].base, tbl[i].n);
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL vec%0d busy got %b want 1", i, busy);
         end
         wait_valid(lat);
         vectors++;
         if (lat != tbl[i].exp_lat) begin
            miscompares++;
            $display("FAIL vec%0d latency got %0d want %0d", i, lat, tbl[i].exp_lat);
         end
         vectors++;
         if (out_data !== tbl[i].exp_data) begin
            miscompares++;
            $display("FAIL vec%0d out_data got %h want %h", i, out_data, tbl[i].exp_data);
         end
         vectors++;
         if (out_ovf !== tbl[i].exp_ovf) begin
            miscompares++;
            $display("FAIL vec%0d out_ovf got %b want %b", i, out_ovf, tbl[i].exp_ovf);
         end
         @(posedge clk);
         #1;
         vectors++;
         if ({out_valid, out_data, out_ovf, busy} !== 23'd0) begin
            miscompares++;
            $display("FAIL vec%0d after_strobe got v=%b d=%h o=%b b=%b want all 0",
                     i, out_valid, out_data, out_ovf, busy);
         end
         $display("vec%0d base=%h n=%0d -> data=%h lat=%0d", i, tbl[i].base, tbl[i].n,
                  tbl[i].exp_data, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(20'h00800, 3'd3);
      wait_valid(lat);
      vectors++;
      if (out_data !== 20'h02000 || lat != 4) begin
         miscompares++;
         $display("FAIL b2b_first got %h lat %0d want 02000 lat 4", out_data, lat);
      end
      // Second request presented during the out_valid cycle.
      issue(20'h00600, 3'd2);
      wait_valid(lat);
      vectors++;
      if (out_data !== 20'h00900 || lat != 3) begin
         miscompares++;
         $display("FAIL b2b_second got %h lat %0d want 00900 lat 3", out_data, lat);
      end
      $display("back_to_back second data=%h lat=%0d", out_data, lat);
   endtask

   task automatic test_busy_ignore();
      int lat;
      int extra;
      issue(20'h00800, 3'd3);
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_in_mul got %b want 1", busy);
      end
      in_data_1 = 20'h00C00;
      in_data_2 = 3'd2;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(lat);
      vectors++;
      if (lat != 3) begin
         miscompares++;
         $display("FAIL busy_first_latency got %0d want 3", lat);
      end
      vectors++;
      if (out_data !== 20'h02000 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL busy_first_data got %h ovf %b want 02000 ovf 0", out_data, out_ovf);
      end
      extra = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL busy_ignored_request got %0d active cycles want 0", extra);
      end
      $display("busy_ignore first data=%h", 20'h02000);
   endtask

   task automatic test_reset_mid_mul();
      int lat;
      int extra;
      issue(20'h00C00, 3'd3);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 20'h0 || out_ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_state got b=%b v=%b d=%h o=%b want all 0",
                  busy, out_valid, out_data, out_ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL midreset_no_strobe got %0d strobes want 0", extra);
      end
      issue(20'h00600, 3'd2);
      wait_valid(lat);
      vectors++;
      if (out_data !== 20'h00900 || lat != 3) begin
         miscompares++;
         $display("FAIL midreset_fresh got %h lat %0d want 00900 lat 3", out_data, lat);
      end
      $display("reset_mid_mul fresh data=%h lat=%0d", out_data, lat);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_power_table();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_mul();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
